// File: rtl/serial_t.sv
// 8N1 serial transmitter (LSB first, idle high); the first bit appears one cycle after accept and each frame lasts 10*BIT_TICKS cycles.
// tx_ready is high only in IDLE, so a byte offered while busy waits. Defining SERIAL_T_PARITY_EN adds an even-parity bit before stop.
module serial_t #(
   parameter int BIT_TICKS = 1301
) (
   input  logic       m_clock,
   input  logic       p_reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       TXD,
   output logic       busy
);

`ifdef SERIAL_T_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [15:0] TICK_MAX = 16'(BIT_TICKS - 1);

   state_t      state_q, state_d;
   logic [15:0] tick_q, tick_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        txd_q, txd_d;
`ifdef SERIAL_T_PARITY_EN
   logic        parity_q, parity_d;
`endif
   logic        tick_end;

   assign tick_end = (tick_q == TICK_MAX);
   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign TXD      = txd_q;

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_end ? 16'd0 : tick_q + 16'd1;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      txd_d    = txd_q;
`ifdef SERIAL_T_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            tick_d = 16'd0;
            txd_d  = 1'b1;
            if (tx_valid) begin
               // Start bit is registered on the accept edge so TXD drops next cycle.
               shreg_d = tx_data;
               state_d = START;
               txd_d   = 1'b0;
`ifdef SERIAL_T_PARITY_EN
               parity_d = ^tx_data;
`endif
            end
         end
         START: begin
            if (tick_end) begin
               state_d  = DATA;
               bitcnt_d = 3'd0;
               txd_d    = shreg_q[0];
            end
         end
         DATA: begin
            if (tick_end) begin
               shreg_d  = shreg_q >> 1;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
`ifdef SERIAL_T_PARITY_EN
                  state_d = PARITY;
                  txd_d   = parity_q;
`else
                  state_d = STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  txd_d = shreg_q[1];
               end
            end
         end
`ifdef SERIAL_T_PARITY_EN
         PARITY: begin
            if (tick_end) begin
               state_d = STOP;
               txd_d   = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick_end) begin
               state_d = IDLE;
               txd_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge m_clock) begin
      if (!p_reset) begin
         state_q  <= IDLE;
         tick_q   <= 16'd0;
         bitcnt_q <= 3'd0;
         shreg_q  <= 8'd0;
         txd_q    <= 1'b1;
`ifdef SERIAL_T_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         txd_q    <= txd_d;
`ifdef SERIAL_T_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_t.sv
// Directed bench for serial_t with BIT_TICKS=4; outputs are sampled 1 time unit after each rising edge.
module tb_serial_t;

   localparam int BT = 4;

   logic       m_clock = 1'b0;
   logic       p_reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       TXD;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   serial_t #(.BIT_TICKS(BT)) dut (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .TXD     (TXD),
      .busy    (busy)
   );

   always #5 m_clock = ~m_clock;

   task automatic step();
      @(posedge m_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
   endtask

   // Called in the first cycle after the accept edge; walks the whole frame.
   task automatic check_frame(input string tag, input logic [7:0] d, input logic par);
      logic [10:0] bits;
      int          nbits;
`ifdef SERIAL_T_PARITY_EN
      nbits = 11;
      bits  = {1'b1, par, d, 1'b0};
`else
      nbits = 10;
      bits  = {1'b0, 1'b1, d, 1'b0};
      if (par) bits[10] = 1'b0;
`endif
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < BT; c++) begin
            chk({tag, "_txd"}, {7'd0, TXD}, {7'd0, bits[b]});
            chk({tag, "_rdy_low"}, {7'd0, tx_ready}, 8'd0);
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            step();
         end
      end
      chk({tag, "_rdy_end"}, {7'd0, tx_ready}, 8'd1);
      chk({tag, "_txd_end"}, {7'd0, TXD}, 8'd1);
      chk({tag, "_busy_end"}, {7'd0, busy}, 8'd0);
   endtask

   initial begin
      p_reset  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_txd", {7'd0, TXD}, 8'd1);
         chk("rst_rdy", {7'd0, tx_ready}, 8'd1);
         chk("rst_busy", {7'd0, busy}, 8'd0);
      end
      p_reset = 1'b1;
      step();

      // Single byte 0xA5: 0, 1,0,1,0,0,1,0,1, 1
      send(8'hA5);
      check_frame("a5", 8'hA5, 1'b0);
      step();

      // Back-to-back with tx_valid held high: exactly one idle cycle between frames.
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      step();
      tx_data  = 8'hFF;
      check_frame("b2b_00", 8'h00, 1'b0);
      step();
      tx_valid = 1'b0;
      check_frame("b2b_ff", 8'hFF, 1'b0);

      // Reset during data bit 2 of 0x0F aborts the frame.
      send(8'h0F);
      for (int i = 0; i < 3 * BT + 1; i++) step();
      chk("mid_bit2", {7'd0, TXD}, 8'd1);
      chk("mid_busy", {7'd0, busy}, 8'd1);
      p_reset = 1'b0;
      step();
      p_reset = 1'b1;
      chk("abort_txd", {7'd0, TXD}, 8'd1);
      chk("abort_rdy", {7'd0, tx_ready}, 8'd1);
      chk("abort_busy", {7'd0, busy}, 8'd0);

      // 0x3C after the abort; a byte offered while busy must be ignored.
      send(8'h3C);
      tx_data  = 8'h99;
      tx_valid = 1'b1;
      check_frame("x3c", 8'h3C, 1'b0);
      tx_valid = 1'b0;
      step();

      // Reset coinciding with an accept drops the byte.
      p_reset  = 1'b0;
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      p_reset  = 1'b1;
      chk("rst_acc_rdy", {7'd0, tx_ready}, 8'd1);
      for (int i = 0; i < BT; i++) begin
         chk("rst_acc_txd", {7'd0, TXD}, 8'd1);
         chk("rst_acc_busy", {7'd0, busy}, 8'd0);
         step();
      end

`ifdef SERIAL_T_PARITY_EN
      send(8'h07);
      check_frame("par07", 8'h07, 1'b1);
      step();
      send(8'h03);
      check_frame("par03", 8'h03, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
